// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: debounced button front-end with reversal rejection, per-step direction commit and pausable step strobe
module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  output logic [1:0] dir,
  output logic       right,
  output logic       left,
  output logic       up,
  output logic       down,
  output logic       game_tick,
  output logic       paused
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(TICK_DIV);
  logic [4:0] raw, sync1_q, sync2_q, stable_q, stable_d, flip, press;
  logic [DW-1:0] cnt_q [5];
  logic [DW-1:0] cnt_d [5];
  logic [TW-1:0] step_q, step_d;
  logic [1:0] dir_q, dir_d, pend_dir_q, pend_dir_d, cand;
  logic [3:0] oh_q, oh_d;
  logic pend_valid_q, pend_valid_d, paused_q, paused_d, accept;
  assign raw = {btnC, btnD, btnU, btnL, btnR};
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      flip[i] = sync2_q[i] != stable_q[i] && cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1);
      cnt_d[i] = (sync2_q[i] == stable_q[i] || flip[i]) ? '0 : cnt_q[i] + 1'b1;
      stable_d[i] = stable_q[i] ^ flip[i];
    end
    press = stable_d & ~stable_q;
    cand = press[0] ? 2'b00 : press[1] ? 2'b01 : press[2] ? 2'b10 : 2'b11;
    // opposite directions differ only in bit 0
    accept = |press[3:0] && cand != {dir_q[1], ~dir_q[0]};
    game_tick = !paused_q && step_q == TW'(TICK_DIV - 1);
    step_d = paused_q ? step_q : game_tick ? '0 : step_q + 1'b1;
    paused_d = paused_q ^ press[4];
    pend_dir_d = accept ? cand : pend_dir_q;
    pend_valid_d = accept || (pend_valid_q && !game_tick);
    dir_d = (game_tick && pend_valid_q) ? pend_dir_q : dir_q;
    oh_d = {dir_d == 2'b00, dir_d == 2'b01, dir_d == 2'b10, dir_d == 2'b11};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      step_q <= '0;
      dir_q <= 2'b00;
      pend_dir_q <= 2'b00;
      pend_valid_q <= 1'b0;
      paused_q <= 1'b0;
      oh_q <= 4'b1000;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      step_q <= step_d;
      dir_q <= dir_d;
      pend_dir_q <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      paused_q <= paused_d;
      oh_q <= oh_d;
    end
  end
  assign dir = dir_q;
  assign {right, left, up, down} = oh_q;
  assign paused = paused_q;
endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: directed table and corner-case sequences for snake_input_ctrl
module tb_snake_input_ctrl;
  logic clk, rst;
  logic [4:0] b;
  logic [1:0] dir;
  logic right, left, up, down, game_tick, paused;
  int total = 0, passed = 0, n;

  snake_input_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(16)) dut (
    .clk(clk), .rst(rst),
    .btnU(b[2]), .btnD(b[3]), .btnL(b[1]), .btnR(b[0]), .btnC(b[4]),
    .dir(dir), .right(right), .left(left), .up(up), .down(down),
    .game_tick(game_tick), .paused(paused)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    logic       acc;
    logic [1:0] d;
  } vec_t;
  vec_t tbl [13];

  localparam logic [4:0] R = 5'b00001, L = 5'b00010, U = 5'b00100, D = 5'b01000, C = 5'b10000;

  function automatic logic [3:0] oh(input logic [1:0] d);
    oh = 4'b1000 >> d;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, got, exp);
  endtask

  task automatic adv(input int k);
    repeat (k) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!game_tick && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!game_tick) begin
      total++;
      $display("FAIL tick_timeout: got 0, want 1");
    end
  endtask

  task automatic count_to_tick(output int k);
    k = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end while (!game_tick && k < 60);
  endtask

  task automatic check_dir(input string name, input logic [1:0] d);
    check({name, "_dir"}, dir, d);
    check({name, "_oh"}, {right, left, up, down}, oh(d));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{L, 1'b0, 2'b00};
    tbl[1]  = '{D, 1'b1, 2'b11};
    tbl[2]  = '{U, 1'b0, 2'b11};
    tbl[3]  = '{L, 1'b1, 2'b01};
    tbl[4]  = '{R, 1'b0, 2'b01};
    tbl[5]  = '{U, 1'b1, 2'b10};
    tbl[6]  = '{D, 1'b0, 2'b10};
    tbl[7]  = '{R | U, 1'b1, 2'b00};
    tbl[8]  = '{L | D, 1'b0, 2'b00};
    tbl[9]  = '{U | D, 1'b1, 2'b10};
    tbl[10] = '{R | L | U | D, 1'b1, 2'b00};
    tbl[11] = '{L | U, 1'b0, 2'b00};
    tbl[12] = '{U, 1'b1, 2'b10};
    rst = 1;
    b = '0;
    repeat (3) @(negedge clk);
    check_dir("rst", 2'b00);
    check("rst_tick", game_tick, 0);
    check("rst_paused", paused, 0);
    rst = 0;
    count_to_tick(n);
    check("first_tick", n, 15);
    count_to_tick(n);
    check("tick_period", n, 16);

    foreach (tbl[i]) begin
      wait_tick();
      b = tbl[i].btn;
      adv(5);
      check($sformatf("v%0d_pv_early", i), dut.pend_valid_q, 0);
      adv(1);
      check($sformatf("v%0d_pv", i), dut.pend_valid_q, tbl[i].acc);
      b = '0;
      wait_tick();
      adv(1);
      check_dir($sformatf("v%0d", i), tbl[i].d);
    end

    wait_tick();
    b = U;
    adv(3);
    b = '0;
    adv(8);
    check("glitch_pv", dut.pend_valid_q, 0);
    wait_tick();
    adv(1);
    check_dir("glitch", 2'b10);

    wait_tick();
    b = R | U;
    adv(6);
    check("prio_pend", dut.pend_dir_q, 2'b00);
    b = D;
    adv(6);
    check("rev_keep_pv", dut.pend_valid_q, 1);
    check("rev_keep_pend", dut.pend_dir_q, 2'b00);
    b = '0;
    wait_tick();
    adv(1);
    check_dir("prio", 2'b00);

    wait_tick();
    b = U;
    adv(6);
    b = D;
    adv(6);
    check("last_wins_pend", dut.pend_dir_q, 2'b11);
    b = '0;
    wait_tick();
    adv(1);
    check_dir("last_wins", 2'b11);

    wait_tick();
    b = L;
    adv(6);
    b = '0;
    wait_tick();
    adv(1);
    check_dir("to_left", 2'b01);

    wait_tick();
    b = U;
    adv(11);
    check("edge_pre_pend", dut.pend_dir_q, 2'b10);
    b = D;
    adv(6);
    b = '0;
    check_dir("edge_commit", 2'b10);
    check("edge_pv", dut.pend_valid_q, 1);
    check("edge_pend", dut.pend_dir_q, 2'b11);
    adv(15);
    check_dir("edge_hold", 2'b10);
    adv(1);
    check_dir("edge_next", 2'b11);

    adv(5);
    rst = 1;
    #1;
    check_dir("rst_mid", 2'b00);
    check("rst_mid_tick", game_tick, 0);
    check("rst_mid_paused", paused, 0);
    check("rst_mid_pv", dut.pend_valid_q, 0);
    @(negedge clk);
    rst = 0;
    count_to_tick(n);
    check("rst_first_tick", n, 15);
    count_to_tick(n);
    check("rst_tick_period", n, 16);

    adv(3);
    b = C;
    adv(6);
    b = '0;
    check("pause_on", paused, 1);
    n = 0;
    repeat (100) begin
      adv(1);
      if (game_tick) n++;
    end
    check("pause_no_tick", n, 0);
    b = U;
    adv(6);
    b = '0;
    check("pause_pv", dut.pend_valid_q, 1);
    check_dir("pause_hold", 2'b00);
    adv(8);
    b = C;
    adv(6);
    b = '0;
    check("pause_off", paused, 0);
    count_to_tick(n);
    check("resume_tick", n, 7);
    adv(1);
    check_dir("resume", 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
